// File: rtl/frame_collect_4.sv
`default_nettype none
// ============================================================================
// Module   : frame_collect_4
// Purpose  : Packs four consecutive samples into a frame for the 4-point
//            butterfly, with a one-frame pending buffer behind the output.
// Revision : 1.0
// ============================================================================
module frame_collect_4 #(
    parameter int WIDTH = 12
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SYNC,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [1:0]       FILL,
    output logic [15:0]      FRAME_CNT
);

    localparam logic [1:0] c_LAST_SLOT = 2'd3;

    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_buf [0:3];
    logic             r_pend;
    logic [WIDTH-1:0] r_out [0:3];
    logic             r_o_valid;
    logic [15:0]      r_frame_cnt;

    logic w_in_ready;
    logic w_out_free;
    logic w_accept;
    logic w_complete;
    logic w_bypass;
    logic w_drain;
    logic w_handoff;

    assign w_in_ready = !r_pend && !SYNC && !RESET;
    assign w_out_free = !r_o_valid || O_READY;
    assign w_accept   = IN_VALID && w_in_ready;
    assign w_complete = w_accept && (r_idx == c_LAST_SLOT);
    assign w_bypass   = w_complete && w_out_free;
    // SYNC throws away the pending frame, so it must not drain in that cycle.
    assign w_drain    = r_pend && w_out_free && !SYNC;
    assign w_handoff  = r_o_valid && O_READY;

    // Collect bank contents are don't-care after reset or realign.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_buf[r_idx] <= IN_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_idx  <= 2'd0;
            r_pend <= 1'b0;
        end else if (SYNC) begin
            r_idx  <= 2'd0;
            r_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_complete && !w_out_free) begin
                r_pend <= 1'b1;
            end else if (w_drain) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_out[0]  <= '0;
            r_out[1]  <= '0;
            r_out[2]  <= '0;
            r_out[3]  <= '0;
            r_o_valid <= 1'b0;
        end else if (w_bypass) begin
            r_out[0]  <= r_buf[0];
            r_out[1]  <= r_buf[1];
            r_out[2]  <= r_buf[2];
            r_out[3]  <= IN_DATA;
            r_o_valid <= 1'b1;
        end else if (w_drain) begin
            r_out[0]  <= r_buf[0];
            r_out[1]  <= r_buf[1];
            r_out[2]  <= r_buf[2];
            r_out[3]  <= r_buf[3];
            r_o_valid <= 1'b1;
        end else if (w_handoff) begin
            r_o_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frame_cnt <= 16'd0;
        end else if (w_handoff) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign IN_READY  = w_in_ready;
    assign O0        = r_out[0];
    assign O1        = r_out[1];
    assign O2        = r_out[2];
    assign O3        = r_out[3];
    assign O_VALID   = r_o_valid;
    assign FILL      = r_idx;
    assign FRAME_CNT = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_collect_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_collect_4
// Purpose  : Self-checking bench for frame_collect_4 against a queue model.
// Revision : 1.0
// ============================================================================
module tb_frame_collect_4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SYNC = 1'b0;
    logic [11:0] IN_DATA = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [11:0] O0, O1, O2, O3;
    logic        O_VALID;
    logic        O_READY = 1'b0;
    logic [1:0]  FILL;
    logic [15:0] FRAME_CNT;

    int n_vec = 0;
    int n_err = 0;

    frame_collect_4 #(.WIDTH(12)) dut (
        .CLK(CLK), .RESET(RESET), .SYNC(SYNC),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .O0(O0), .O1(O1), .O2(O2), .O3(O3),
        .O_VALID(O_VALID), .O_READY(O_READY),
        .FILL(FILL), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    logic [11:0] dut_o [4];
    assign dut_o[0] = O0;
    assign dut_o[1] = O1;
    assign dut_o[2] = O2;
    assign dut_o[3] = O3;

    // Reference model: samples collected so far, a parked frame, the presented frame.
    logic [11:0] m_part [$];
    logic [11:0] m_pframe [4];
    logic [11:0] m_o [4];
    bit          m_pend;
    bit          m_ov;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_part.delete();
        m_pend = 0;
        m_ov   = 0;
        m_cnt  = 16'd0;
        for (int i = 0; i < 4; i++) begin
            m_o[i]      = 12'd0;
            m_pframe[i] = 12'd0;
        end
    endtask

    task automatic model_step();
        bit free, hs, loaded;
        free   = !m_ov || O_READY;
        hs     = m_ov && O_READY;
        loaded = 0;
        if (hs) m_cnt = m_cnt + 16'd1;
        if (SYNC) begin
            m_part.delete();
            m_pend = 0;
        end else if (IN_VALID && !m_pend) begin
            m_part.push_back(IN_DATA);
            if (m_part.size() == 4) begin
                if (free) begin
                    for (int i = 0; i < 4; i++) m_o[i] = m_part[i];
                    m_ov   = 1;
                    loaded = 1;
                end else begin
                    for (int i = 0; i < 4; i++) m_pframe[i] = m_part[i];
                    m_pend = 1;
                end
                m_part.delete();
            end
        end else if (m_pend && free) begin
            for (int i = 0; i < 4; i++) m_o[i] = m_pframe[i];
            m_ov   = 1;
            m_pend = 0;
            loaded = 1;
        end
        if (hs && !loaded) m_ov = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit v, input logic [11:0] d, input bit r, input bit s);
        IN_VALID = v;
        IN_DATA  = d;
        O_READY  = r;
        SYNC     = s;
        #1;
    endtask

    task automatic test_reset();
        n_vec++;
        if (O_VALID !== 1'b0 || FILL !== 2'd0 || FRAME_CNT !== 16'd0 || IN_READY !== 1'b0 || O0 !== 12'd0) begin
            n_err++;
            $display("FAIL reset_hold: ov=%b fill=%0d cnt=%h rdy=%b o0=%h, want all zero", O_VALID, FILL, FRAME_CNT, IN_READY, O0);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 1", IN_READY);
        end
        // Build O_VALID=1 and FILL=2, then hit RESET mid-cycle.
        for (int i = 0; i < 6; i++) begin
            drive(1, 12'h300 + 12'(i), 0, 0);
            cycle();
        end
        drive(0, 12'h0, 0, 0);
        n_vec++;
        if (O_VALID !== 1'b1 || FILL !== 2'd2) begin
            n_err++;
            $display("FAIL reset_precond: ov=%b fill=%0d want ov=1 fill=2", O_VALID, FILL);
        end
        #1 RESET = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (O_VALID !== 1'b0 || FILL !== 2'd0 || FRAME_CNT !== 16'd0 || IN_READY !== 1'b0 ||
            O0 !== 12'd0 || O1 !== 12'd0 || O2 !== 12'd0 || O3 !== 12'd0) begin
            n_err++;
            $display("FAIL reset_async: ov=%b fill=%0d cnt=%h rdy=%b o=%h %h %h %h, want zeros",
                     O_VALID, FILL, FRAME_CNT, IN_READY, O0, O1, O2, O3);
        end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        n_vec++;
        if (IN_READY !== 1'b1 || FILL !== 2'd0) begin
            n_err++;
            $display("FAIL reset_after: rdy=%b fill=%0d want rdy=1 fill=0", IN_READY, FILL);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] cnt0;
        cnt0 = FRAME_CNT;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 12'(i), 1, 0);
            n_vec++;
            if (IN_READY !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, IN_READY);
            end
            cycle();
            if (i == 4 || i == 8) begin
                n_vec++;
                if (O_VALID !== 1'b1 || O0 !== 12'(i-3) || O1 !== 12'(i-2) || O2 !== 12'(i-1) || O3 !== 12'(i)) begin
                    n_err++;
                    $display("FAIL stream_frame%0d: ov=%b o=%h %h %h %h want 1 %h %h %h %h",
                             i/4, O_VALID, O0, O1, O2, O3, 12'(i-3), 12'(i-2), 12'(i-1), 12'(i));
                end
            end
        end
        drive(0, 12'h0, 1, 0);
        cycle();
        n_vec++;
        if (FRAME_CNT !== cnt0 + 16'd2 || O_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL stream_cnt: cnt=%h ov=%b want cnt=%h ov=0", FRAME_CNT, O_VALID, cnt0 + 16'd2);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) begin
            drive(1, 12'h010 + 12'(i), 0, 0);
            cycle();
            if (i >= 3) begin
                n_vec++;
                if (O_VALID !== 1'b1 || O0 !== 12'h010 || O1 !== 12'h011 || O2 !== 12'h012 || O3 !== 12'h013) begin
                    n_err++;
                    $display("FAIL bp_hold[%0d]: ov=%b o=%h %h %h %h want 1 010 011 012 013", i, O_VALID, O0, O1, O2, O3);
                end
            end
        end
        drive(0, 12'h0, 0, 0);
        n_vec++;
        if (IN_READY !== 1'b0 || dut.r_pend !== 1'b1) begin
            n_err++;
            $display("FAIL bp_pend: rdy=%b pend=%b want rdy=0 pend=1", IN_READY, dut.r_pend);
        end
        drive(0, 12'h0, 1, 0);
        cycle();
        drive(0, 12'h0, 0, 0);
        n_vec++;
        if (O_VALID !== 1'b1 || O0 !== 12'h014 || O1 !== 12'h015 || O2 !== 12'h016 || O3 !== 12'h017 || IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drain: ov=%b o=%h %h %h %h rdy=%b want 1 014 015 016 017 rdy=1",
                     O_VALID, O0, O1, O2, O3, IN_READY);
        end
    endtask

    task automatic test_sync();
        drive(1, 12'hAAA, 0, 0); cycle();
        drive(1, 12'hBBB, 0, 0); cycle();
        n_vec++;
        if (FILL !== 2'd2) begin
            n_err++;
            $display("FAIL sync_pre_fill: got %0d want 2", FILL);
        end
        drive(1, 12'hCCC, 0, 1);
        n_vec++;
        if (IN_READY !== 1'b0) begin
            n_err++;
            $display("FAIL sync_ready: got %b want 0", IN_READY);
        end
        cycle();
        n_vec++;
        if (FILL !== 2'd0 || O_VALID !== 1'b1 || O0 !== 12'h014) begin
            n_err++;
            $display("FAIL sync_fill: fill=%0d ov=%b o0=%h want 0 1 014", FILL, O_VALID, O0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 12'h100 + 12'(i), 1, 0);
            cycle();
        end
        n_vec++;
        if (O_VALID !== 1'b1 || O0 !== 12'h100 || O1 !== 12'h101 || O2 !== 12'h102 || O3 !== 12'h103) begin
            n_err++;
            $display("FAIL sync_frame: ov=%b o=%h %h %h %h want 1 100 101 102 103", O_VALID, O0, O1, O2, O3);
        end
    endtask

    task automatic test_coincident();
        logic [15:0] cnt0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 12'h200 + 12'(i), 0, 0);
            cycle();
        end
        cnt0 = FRAME_CNT;
        drive(1, 12'h203, 1, 0);
        cycle();
        n_vec++;
        if (O_VALID !== 1'b1 || FRAME_CNT !== cnt0 + 16'd1 || O0 !== 12'h200 || O3 !== 12'h203 || IN_READY !== 1'b1) begin
            n_err++;
            $display("FAIL coincident: ov=%b cnt=%h o0=%h o3=%h rdy=%b want 1 %h 200 203 1",
                     O_VALID, FRAME_CNT, O0, O3, IN_READY, cnt0 + 16'd1);
        end
        drive(0, 12'h0, 1, 0);
        cycle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            drive(1, 12'h400 + 12'(i), 0, 0);
            cycle();
        end
        drive(0, 12'h0, 0, 0);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        m_cnt = 16'hFFFF;
        #1;
        n_vec++;
        if (FRAME_CNT !== 16'hFFFF) begin
            n_err++;
            $display("FAIL wrap_preload: got %h want ffff", FRAME_CNT);
        end
        drive(0, 12'h0, 1, 0);
        cycle();
        n_vec++;
        if (FRAME_CNT !== 16'h0000 || O_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL wrap: cnt=%h ov=%b want 0000 0", FRAME_CNT, O_VALID);
        end
    endtask

    task automatic test_random();
        bit v, r, s;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) != 0);
            s = ($urandom_range(0, 31) == 0);
            drive(v, 12'($urandom), r, s);
            n_vec++;
            if (IN_READY !== (!m_pend && !s)) begin
                n_err++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", n, IN_READY, !m_pend && !s);
            end
            cycle();
            n_vec++;
            if (O_VALID !== m_ov || FILL !== 2'(m_part.size()) || FRAME_CNT !== m_cnt) begin
                n_err++;
                $display("FAIL rnd_state[%0d]: ov=%b fill=%0d cnt=%h want %b %0d %h",
                         n, O_VALID, FILL, FRAME_CNT, m_ov, m_part.size(), m_cnt);
            end
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (dut_o[k] !== m_o[k]) begin
                    n_err++;
                    $display("FAIL rnd_o%0d[%0d]: got %h want %h", k, n, dut_o[k], m_o[k]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_streaming();
        test_backpressure();
        test_sync();
        test_coincident();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
